// File: rtl/majority_pkg.sv
// Shared types and limits for the majority window voter.
// FSM encoding, verdict bit order and legal window sizes.
package majority_pkg;

    localparam int WIN_MIN = 2;
    localparam int WIN_MAX = 255;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_REPORT  = 1'b1
    } state_t;

    // Verdict bit order is {out, equal}.
    typedef struct packed {
        logic out;
        logic equal;
    } verdict_t;

endpackage

// File: rtl/majority_window_voter_if.sv
// Sample stream in, verdict stream out, both valid/ready.
// MAJORITY_MINORITY_OUT_EN adds the minority verdict bit.
interface majority_window_voter_if #(
    parameter int CW = 3
);
    logic          in_valid;
    logic          in_bit;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          out;
    logic          equal;
    logic [CW-1:0] ones_cnt;
`ifdef MAJORITY_MINORITY_OUT_EN
    logic          minority;

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out, equal, ones_cnt, minority
    );
    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out, equal, ones_cnt, minority
    );
`else
    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out, equal, ones_cnt
    );
    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out, equal, ones_cnt
    );
`endif
endinterface

// File: rtl/window_ones_counter.sv
// Sample and ones counters for one window of WIN samples.
// o_last flags that the accepted sample closes the window.
module window_ones_counter #(
    parameter int WIN = 4,
    parameter int CW  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_accept,
    input  logic          i_bit,
    input  logic          i_clear,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_ones,
    output logic          o_last
);
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_ones;

    // Count accepted samples and ones; clear wins over accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_ones  <= '0;
        end else if (i_clear) begin
            r_count <= '0;
            r_ones  <= '0;
        end else if (i_accept) begin
            r_count <= r_count + CW'(1);
            r_ones  <= r_ones + CW'(i_bit);
        end
    end

    assign o_count = r_count;
    assign o_ones  = r_ones;
    assign o_last  = i_accept && (r_count == CW'(WIN - 1));

endmodule

// File: rtl/majority_window_voter.sv
// Windowed majority voter: WIN samples in, one verdict out.
// Optional minority output under MAJORITY_MINORITY_OUT_EN.
module majority_window_voter
    import majority_pkg::*;
#(
    parameter  int WIN = 4,
    localparam int CW  = $clog2(WIN + 1)
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  clr,
    majority_window_voter_if.slave bus
);
    localparam logic [CW:0] WIN_W = (CW + 1)'(WIN);

    if (WIN < WIN_MIN || WIN > WIN_MAX) begin : g_bad_win
        $error("majority_window_voter: WIN out of range");
    end

    state_t        r_state;
    verdict_t      r_verdict;
    logic [CW-1:0] r_ones;
`ifdef MAJORITY_MINORITY_OUT_EN
    logic          r_minority;
`endif

    logic          w_accept;
    logic          w_clear;
    logic          w_last;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_ones;
    logic [CW-1:0] w_final;
    logic [CW:0]   w_dbl;
    verdict_t      w_vote;

    // The count guard keeps a full window from taking an extra slot.
    assign bus.in_ready  = (r_state == ST_COLLECT) &&
                           (w_count < CW'(WIN));
    assign bus.out_valid = (r_state == ST_REPORT);

    // A sample offered alongside clr is dropped.
    assign w_accept = bus.in_valid & bus.in_ready & ~clr;
    assign w_clear  = clr | (bus.out_valid & bus.out_ready);

    window_ones_counter #(
        .WIN (WIN),
        .CW  (CW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_accept (w_accept),
        .i_bit    (bus.in_bit),
        .i_clear  (w_clear),
        .o_count  (w_count),
        .o_ones   (w_ones),
        .o_last   (w_last)
    );

    // Final count includes the closing sample; one extra bit holds 2*ones.
    assign w_final      = w_ones + CW'(bus.in_bit);
    assign w_dbl        = {w_final, 1'b0};
    assign w_vote.out   = (w_dbl > WIN_W);
    assign w_vote.equal = (w_dbl == WIN_W);

    // Window FSM with registered verdict; verdict is zero outside REPORT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_COLLECT;
            r_verdict <= '0;
            r_ones    <= '0;
`ifdef MAJORITY_MINORITY_OUT_EN
            r_minority <= 1'b0;
`endif
        end else if (clr) begin
            r_state   <= ST_COLLECT;
            r_verdict <= '0;
            r_ones    <= '0;
`ifdef MAJORITY_MINORITY_OUT_EN
            r_minority <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_COLLECT: begin
                    if (w_last) begin
                        r_state   <= ST_REPORT;
                        r_verdict <= w_vote;
                        r_ones    <= w_final;
`ifdef MAJORITY_MINORITY_OUT_EN
                        r_minority <= ~w_vote.out & ~w_vote.equal;
`endif
                    end
                end
                ST_REPORT: begin
                    if (bus.out_ready) begin
                        r_state   <= ST_COLLECT;
                        r_verdict <= '0;
                        r_ones    <= '0;
`ifdef MAJORITY_MINORITY_OUT_EN
                        r_minority <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    assign bus.out      = r_verdict.out;
    assign bus.equal    = r_verdict.equal;
    assign bus.ones_cnt = r_ones;
`ifdef MAJORITY_MINORITY_OUT_EN
    assign bus.minority = r_minority;
`endif

endmodule

// File: tb/tb_majority_window_voter.sv
// Directed bench for majority_window_voter (WIN=4 and WIN=5).
// Expected verdicts are queued at stimulus time and popped on output.
module tb_majority_window_voter;

    localparam int CW4 = $clog2(4 + 1);
    localparam int CW5 = $clog2(5 + 1);

    logic clk = 1'b0;
    logic rst;
    logic clr4;
    logic clr5;

    majority_window_voter_if #(.CW(CW4)) bus4();
    majority_window_voter_if #(.CW(CW5)) bus5();

    majority_window_voter #(.WIN(4)) u4 (
        .clk (clk),
        .rst (rst),
        .clr (clr4),
        .bus (bus4)
    );

    majority_window_voter #(.WIN(5)) u5 (
        .clk (clk),
        .rst (rst),
        .clr (clr5),
        .bus (bus5)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic o;
        logic e;
        int   ones;
    } exp_t;

    exp_t q4[$];
    exp_t q5[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic exp_t model(int ones, int win);
        exp_t r;
        r.o    = (ones * 2 > win);
        r.e    = (ones * 2 == win);
        r.ones = ones;
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(logic b);
        for (int i = 0; i < 30 && bus4.in_ready !== 1'b1; i++) step();
        chk("send4_ready", 32'(bus4.in_ready), 1);
        bus4.in_valid = 1'b1;
        bus4.in_bit   = b;
        step();
        bus4.in_valid = 1'b0;
    endtask

    // s[3] is sent first.
    task automatic win4(logic [3:0] s);
        q4.push_back(model($countones(s), 4));
        for (int i = 3; i >= 0; i--) send4(s[i]);
    endtask

    task automatic get4(string tag);
        exp_t e;
        for (int i = 0; i < 30 && bus4.out_valid !== 1'b1; i++) step();
        chk({tag, "_valid"}, 32'(bus4.out_valid), 1);
        e = q4.pop_front();
        chk({tag, "_out"}, 32'(bus4.out), 32'(e.o));
        chk({tag, "_equal"}, 32'(bus4.equal), 32'(e.e));
        chk({tag, "_ones"}, 32'(bus4.ones_cnt), 32'(e.ones));
`ifdef MAJORITY_MINORITY_OUT_EN
        chk({tag, "_min"}, 32'(bus4.minority), 32'(~e.o & ~e.e));
`endif
        if (bus4.out_ready === 1'b1) begin
            step();
            chk({tag, "_drop"}, 32'(bus4.out_valid), 0);
            chk({tag, "_rdy"}, 32'(bus4.in_ready), 1);
            chk({tag, "_zero"}, 32'(bus4.ones_cnt), 0);
        end
    endtask

    initial begin
        exp_t e;
        rst  = 1'b1;
        clr4 = 1'b0;
        clr5 = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.in_bit    = 1'b0;
        bus4.out_ready = 1'b1;
        bus5.in_valid  = 1'b0;
        bus5.in_bit    = 1'b0;
        bus5.out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(bus4.out_valid), 0);
        chk("rst_out", 32'(bus4.out), 0);
        chk("rst_equal", 32'(bus4.equal), 0);
        chk("rst_ones", 32'(bus4.ones_cnt), 0);
        rst = 1'b0;
        step();
        chk("rst_ready", 32'(bus4.in_ready), 1);

        // 1: 1,1,0,1 back-to-back
        win4(4'b1101);
        chk("t1_latency", 32'(bus4.out_valid), 1);
        chk("t1_in_ready", 32'(bus4.in_ready), 0);
        get4("t1");

        // 2: tie, then minority, then all-zero
        win4(4'b1001);
        get4("t2a");
        win4(4'b0001);
        get4("t2b");
        win4(4'b0000);
        get4("t2zero");

        // 3: WIN=5 with 3 idle cycles between samples
        begin
            logic [4:0] s5;
            s5 = 5'b10100;
            q5.push_back(model($countones(s5), 5));
            for (int k = 0; k < 5; k++) begin
                chk("t3_ready", 32'(bus5.in_ready), 1);
                bus5.in_valid = 1'b1;
                bus5.in_bit   = s5[4-k];
                step();
                bus5.in_valid = 1'b0;
                if (k < 4) begin
                    for (int g = 0; g < 3; g++) begin
                        step();
                        chk("t3_hold_cnt", 32'(u5.u_cnt.o_count), k + 1);
                        chk("t3_idle_valid", 32'(bus5.out_valid), 0);
                    end
                end
            end
            e = q5.pop_front();
            chk("t3_valid", 32'(bus5.out_valid), 1);
            chk("t3_out", 32'(bus5.out), 32'(e.o));
            chk("t3_equal", 32'(bus5.equal), 32'(e.e));
            chk("t3_ones", 32'(bus5.ones_cnt), 32'(e.ones));
            step();
            chk("t3_drop", 32'(bus5.out_valid), 0);
        end

        // 4: out_ready low for 10 cycles, samples offered meanwhile
        bus4.out_ready = 1'b0;
        win4(4'b1110);
        bus4.in_valid = 1'b1;
        bus4.in_bit   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_valid", 32'(bus4.out_valid), 1);
            chk("t4_out", 32'(bus4.out), 1);
            chk("t4_ones", 32'(bus4.ones_cnt), 3);
            chk("t4_in_ready", 32'(bus4.in_ready), 0);
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        get4("t4");
        win4(4'b0000);
        get4("t4next");

        // 5: clr mid-window with a sample offered, then clr in REPORT
        send4(1'b1);
        send4(1'b1);
        clr4 = 1'b1;
        bus4.in_valid = 1'b1;
        bus4.in_bit   = 1'b1;
        step();
        clr4 = 1'b0;
        bus4.in_valid = 1'b0;
        chk("t5_cnt_clr", 32'(u4.u_cnt.o_count), 0);
        win4(4'b1000);
        get4("t5a");
        send4(1'b1);
        send4(1'b1);
        send4(1'b0);
        send4(1'b1);
        chk("t5_rep_valid", 32'(bus4.out_valid), 1);
        clr4 = 1'b1;
        step();
        clr4 = 1'b0;
        chk("t5_clr_valid", 32'(bus4.out_valid), 0);
        chk("t5_clr_out", 32'(bus4.out), 0);
        chk("t5_clr_ones", 32'(bus4.ones_cnt), 0);
        step();
        chk("t5_clr_stay", 32'(bus4.out_valid), 0);
        win4(4'b0111);
        get4("t5b");

        // 6: async rst mid-window and mid-REPORT
        send4(1'b1);
        send4(1'b1);
        #3 rst = 1'b1;
        #1;
        chk("t6_cnt", 32'(u4.u_cnt.o_count), 0);
        chk("t6_ones_int", 32'(u4.u_cnt.o_ones), 0);
        chk("t6_valid", 32'(bus4.out_valid), 0);
        #1 rst = 1'b0;
        step();
        bus4.out_ready = 1'b0;
        send4(1'b1);
        send4(1'b1);
        send4(1'b1);
        send4(1'b1);
        chk("t6_rep_valid", 32'(bus4.out_valid), 1);
        #3 rst = 1'b1;
        #1;
        chk("t6r_valid", 32'(bus4.out_valid), 0);
        chk("t6r_out", 32'(bus4.out), 0);
        chk("t6r_equal", 32'(bus4.equal), 0);
        chk("t6r_ones", 32'(bus4.ones_cnt), 0);
        chk("t6r_ready", 32'(bus4.in_ready), 1);
        #1 rst = 1'b0;
        step();
        bus4.out_ready = 1'b1;
        win4(4'b1100);
        get4("t6");

        chk("q4_empty", 32'(q4.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
